// File: rtl/riscv_core_div_out.sv
// -----------------------------------------------------------------------------
// riscv_core_div_out
//
// Result stage of the RV64 M-extension divider. An issue pulse captures the
// operation type, the operand sign information and the divide-by-zero and
// signed-overflow special cases. The stage then waits for the unsigned
// iterative divider core to report quotient/remainder magnitudes, applies
// sign correction and the RISC-V special-case rules, sign-extends W-form
// results, and presents the final rd value behind a valid/ready handshake.
//
// Optional feature macro: DIV_OUT_SPECIAL_EN
//   defined   : a divide-by-zero or overflow op skips the core. The stage goes
//               straight to DONE, with the result valid the cycle after start.
//               o_div_out_core_kill pulses for one cycle to abort the core.
//   undefined : every op waits for the core. core_kill is tied low.
//
// Ports
//   i_clk                clock, all state on the rising edge
//   i_rst                synchronous active-high reset
//   i_div_out_start      issue pulse, accepted only while not busy
//   i_div_out_srcA/B     original signed-form dividend / divisor
//   i_div_out_control    00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_div_out_isword     W variant (operates on the low XLEN/2 bits)
//   i_div_out_core_done  core pulse: magnitudes valid this cycle
//   i_div_out_quotient   unsigned quotient magnitude from the core
//   i_div_out_remainder  unsigned remainder magnitude from the core
//   o_div_out_core_kill  one-cycle core abort (special-case bypass only)
//   o_div_out_busy       high while an op is in flight or a result is held
//   o_div_out_valid      final result valid
//   i_div_out_ready      writeback accepts when valid & ready
//   o_div_out_result     final rd value
// -----------------------------------------------------------------------------
module riscv_core_div_out #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_div_out_start,
    input  logic [XLEN-1:0] i_div_out_srcA,
    input  logic [XLEN-1:0] i_div_out_srcB,
    input  logic [1:0]      i_div_out_control,
    input  logic            i_div_out_isword,
    input  logic            i_div_out_core_done,
    input  logic [XLEN-1:0] i_div_out_quotient,
    input  logic [XLEN-1:0] i_div_out_remainder,
    output logic            o_div_out_core_kill,
    output logic            o_div_out_busy,
    output logic            o_div_out_valid,
    input  logic            i_div_out_ready,
    output logic [XLEN-1:0] o_div_out_result
);

    localparam int H = XLEN / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Per-op information captured at issue
    logic [1:0]      ctrl_q;
    logic            isword_q;
    logic            dz_q;
    logic            ovf_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] dividend_q;

    logic [XLEN-1:0] result_q, result_d;

    // Decode of the live issue operands
    logic            signed_op;
    logic            sign_a;
    logic            sign_b;
    logic            dz_in;
    logic            ovf_in;
    logic [XLEN-1:0] dividend_in;
    logic            start_acc;
    logic            special_in;

    always_comb begin
        signed_op = ~i_div_out_control[0];
        if (i_div_out_isword) begin
            sign_a      = i_div_out_srcA[H-1];
            sign_b      = i_div_out_srcB[H-1];
            dz_in       = (i_div_out_srcB[H-1:0] == '0);
            ovf_in      = signed_op
                        & (i_div_out_srcA[H-1:0] == {1'b1, {(H-1){1'b0}}})
                        & (i_div_out_srcB[H-1:0] == {H{1'b1}});
            dividend_in = {{(XLEN-H){1'b0}}, i_div_out_srcA[H-1:0]};
        end else begin
            sign_a      = i_div_out_srcA[XLEN-1];
            sign_b      = i_div_out_srcB[XLEN-1];
            dz_in       = (i_div_out_srcB == '0);
            ovf_in      = signed_op
                        & (i_div_out_srcA == {1'b1, {(XLEN-1){1'b0}}})
                        & (i_div_out_srcB == {XLEN{1'b1}});
            dividend_in = i_div_out_srcA;
        end
        start_acc = (state_q == S_IDLE) & i_div_out_start;
    end

`ifdef DIV_OUT_SPECIAL_EN
    assign special_in = dz_in | ovf_in;
`else
    assign special_in = 1'b0;
`endif

    // Sign-correct the core magnitude, then apply the special cases.
    // Divide-by-zero wins over overflow. W results are sign-extended from
    // bit H-1 for every W op, unsigned ones included.
    function automatic logic [XLEN-1:0] finalize(
        input logic [1:0]      ctrl,
        input logic            isword,
        input logic            dz,
        input logic            ovf,
        input logic            neg_quo,
        input logic            neg_rem,
        input logic [XLEN-1:0] dividend,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem
    );
        logic [XLEN-1:0] raw;
        logic [XLEN-1:0] val;
        logic            neg;
        raw = ctrl[1] ? rem : quo;
        neg = ctrl[1] ? neg_rem : neg_quo;
        val = neg ? ((~raw) + XLEN'(1)) : raw;
        if (dz) begin
            val = ctrl[1] ? dividend : {XLEN{1'b1}};
        end else if (ovf) begin
            val = ctrl[1] ? '0 : dividend;
        end
        if (isword) begin
            val = {{(XLEN-H){val[H-1]}}, val[H-1:0]};
        end
        return val;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_div_out_start) state_d = special_in ? S_DONE : S_WAIT;
            S_WAIT: if (i_div_out_core_done) state_d = S_DONE;
            S_DONE: if (i_div_out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- Result datapath ----------------
    always_comb begin
        result_d = result_q;
        if (start_acc && special_in) begin
            // Bypass: the overrides do not depend on the core output.
            result_d = finalize(i_div_out_control, i_div_out_isword, dz_in, ovf_in,
                                1'b0, 1'b0, dividend_in, '0, '0);
        end else if (state_q == S_WAIT && i_div_out_core_done) begin
            result_d = finalize(ctrl_q, isword_q, dz_q, ovf_q, neg_quo_q, neg_rem_q,
                                dividend_q, i_div_out_quotient, i_div_out_remainder);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_q     <= '0;
            isword_q   <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dividend_q <= '0;
            result_q   <= '0;
        end else begin
            if (start_acc) begin
                ctrl_q     <= i_div_out_control;
                isword_q   <= i_div_out_isword;
                dz_q       <= dz_in;
                ovf_q      <= ovf_in;
                neg_quo_q  <= signed_op & (sign_a ^ sign_b);
                neg_rem_q  <= signed_op & sign_a;
                dividend_q <= dividend_in;
            end
            result_q <= result_d;
        end
    end

`ifdef DIV_OUT_SPECIAL_EN
    // Registered so the pulse lines up with the first cycle in DONE.
    logic kill_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            kill_q <= 1'b0;
        end else begin
            kill_q <= start_acc & special_in;
        end
    end
`endif

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_div_out_busy   = (state_q != S_IDLE);
        o_div_out_valid  = (state_q == S_DONE);
`ifdef DIV_OUT_SPECIAL_EN
        o_div_out_core_kill = kill_q;
`else
        o_div_out_core_kill = 1'b0;
`endif
    end

    assign o_div_out_result = result_q;

endmodule

// File: tb/tb_riscv_core_div_out.sv
module tb_riscv_core_div_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] srcA, srcB;
    logic [1:0]  control;
    logic        isword;
    logic        core_done;
    logic [63:0] quotient, remainder;
    logic        core_kill, busy, valid;
    logic        ready;
    logic [63:0] result;

    always #5 clk = ~clk;

    riscv_core_div_out #(.XLEN(64)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_div_out_start     (start),
        .i_div_out_srcA      (srcA),
        .i_div_out_srcB      (srcB),
        .i_div_out_control   (control),
        .i_div_out_isword    (isword),
        .i_div_out_core_done (core_done),
        .i_div_out_quotient  (quotient),
        .i_div_out_remainder (remainder),
        .o_div_out_core_kill (core_kill),
        .o_div_out_busy      (busy),
        .o_div_out_valid     (valid),
        .i_div_out_ready     (ready),
        .o_div_out_result    (result)
    );

    int checks   = 0;
    int failures = 0;

    // Expected handshake-level view of the DUT, maintained by the driver
    bit          checking  = 1'b0;
    logic        mdl_busy  = 1'b0;
    logic        mdl_valid = 1'b0;
    logic        mdl_kill  = 1'b0;
    logic [63:0] mdl_result = '0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural RISC-V M-extension result, straight from the ISA rules
    function automatic logic [63:0] ref_result(input logic [1:0] ctrl, input bit w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r64;
        logic [31:0] r32;
        if (w) begin
            logic        [31:0] ua, ub;
            logic signed [31:0] sa, sb;
            ua = a[31:0]; ub = b[31:0]; sa = a[31:0]; sb = b[31:0];
            case (ctrl)
                2'b00: if (ub == 0) r32 = '1;
                       else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
                       else r32 = sa / sb;
                2'b01: if (ub == 0) r32 = '1; else r32 = ua / ub;
                2'b10: if (ub == 0) r32 = ua;
                       else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = '0;
                       else r32 = sa % sb;
                default: if (ub == 0) r32 = ua; else r32 = ua % ub;
            endcase
            r64 = {{32{r32[31]}}, r32};
        end else begin
            logic signed [63:0] sa, sb;
            sa = a; sb = b;
            case (ctrl)
                2'b00: if (b == 0) r64 = '1;
                       else if (a == MIN64 && b == '1) r64 = a;
                       else r64 = sa / sb;
                2'b01: if (b == 0) r64 = '1; else r64 = a / b;
                2'b10: if (b == 0) r64 = a;
                       else if (a == MIN64 && b == '1) r64 = '0;
                       else r64 = sa % sb;
                default: if (b == 0) r64 = a; else r64 = a % b;
            endcase
        end
        return r64;
    endfunction

    // What an unsigned magnitude divider core would report
    task automatic core_mag(input logic [1:0] ctrl, input bit w, input logic [63:0] a,
                            input logic [63:0] b, output logic [63:0] q, output logic [63:0] r);
        bit sg;
        sg = ~ctrl[0];
        if (w) begin
            logic [31:0] ma, mb;
            ma = (sg && a[31]) ? -a[31:0] : a[31:0];
            mb = (sg && b[31]) ? -b[31:0] : b[31:0];
            if (mb == 0) begin q = 64'h0000_0000_FFFF_FFFF; r = {32'h0, ma}; end
            else begin q = {32'h0, ma / mb}; r = {32'h0, ma % mb}; end
        end else begin
            logic [63:0] ma, mb;
            ma = (sg && a[63]) ? -a : a;
            mb = (sg && b[63]) ? -b : b;
            if (mb == 0) begin q = '1; r = ma; end
            else begin q = ma / mb; r = ma % mb; end
        end
    endtask

    function automatic bit is_special(input logic [1:0] ctrl, input bit w,
                                      input logic [63:0] a, input logic [63:0] b);
        if (w) return (b[31:0] == 0) ||
                      (!ctrl[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (!ctrl[0] && a == MIN64 && b == '1);
    endfunction

    // Compare process: every cycle after reset, against the expected view
    always @(negedge clk) begin
        if (checking) begin
            chk("busy", {63'b0, busy}, {63'b0, mdl_busy});
            chk("valid", {63'b0, valid}, {63'b0, mdl_valid});
            chk("core_kill", {63'b0, core_kill}, {63'b0, mdl_kill});
            if (mdl_valid) chk("result", result, mdl_result);
        end
    end

    task automatic do_op(input logic [1:0] ctrl, input bit w, input logic [63:0] a,
                         input logic [63:0] b, input int lat, input int hold,
                         input bit collide, input bit has_lit, input logic [63:0] lit);
        logic [63:0] exp, q, r;
        bit special;
        exp = ref_result(ctrl, w, a, b);
        if (has_lit) chk("model_pin", exp, lit);
        core_mag(ctrl, w, a, b, q, r);
        special = 1'b0;
`ifdef DIV_OUT_SPECIAL_EN
        special = is_special(ctrl, w, a, b);
`endif
        // Issue (optionally with a stray core_done in the same cycle)
        start = 1'b1; srcA = a; srcB = b; control = ctrl; isword = w;
        if (collide) begin
            core_done = 1'b1; quotient = {$urandom, $urandom}; remainder = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        start = 1'b0; core_done = 1'b0;
        srcA = {$urandom, $urandom}; srcB = {$urandom, $urandom};
        control = 2'($urandom); isword = 1'($urandom);
        if (special) begin
            mdl_busy = 1'b1; mdl_valid = 1'b1; mdl_kill = 1'b1; mdl_result = exp;
            @(posedge clk); #1;
            mdl_kill = 1'b0;
            // A late core_done must not disturb the held result
            core_done = 1'b1; quotient = {$urandom, $urandom}; remainder = {$urandom, $urandom};
            @(posedge clk); #1;
            core_done = 1'b0;
        end else begin
            mdl_busy = 1'b1; mdl_valid = 1'b0;
            repeat (lat - 1) begin @(posedge clk); #1; end
            core_done = 1'b1; quotient = q; remainder = r;
            @(posedge clk); #1;
            core_done = 1'b0; quotient = {$urandom, $urandom}; remainder = {$urandom, $urandom};
            mdl_valid = 1'b1; mdl_result = exp;
        end
        if (has_lit) chk("literal_result", result, lit);
        // Hold in DONE with ready low; a start in the middle must be ignored
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                start = 1'b1; srcA = 64'd9; srcB = 64'd0; control = 2'b00; isword = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        mdl_valid = 1'b0; mdl_busy = 1'b0;
        $display("op ctrl=%0d w=%0d a=%h b=%h lat=%0d hold=%0d expected=%h",
                 ctrl, w, a, b, lat, hold, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; srcA = '0; srcB = '0; control = '0; isword = 1'b0;
        core_done = 1'b0; quotient = '0; remainder = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_valid", {63'b0, valid}, 64'd0);
        chk("reset_kill", {63'b0, core_kill}, 64'd0);
        chk("reset_result", result, 64'd0);
        checking = 1'b1;

        // Signed correction
        do_op(2'b00, 1'b0, -64'sd7, 64'd2, 3, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(2'b10, 1'b0, -64'sd7, 64'd2, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        // W forms
        do_op(2'b01, 1'b1, 64'h8000_0000, 64'd1, 2, 0, 0, 1, 64'hFFFF_FFFF_8000_0000);
        do_op(2'b10, 1'b1, 64'hFFFF_FFF9, 64'd2, 4, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        // Divide by zero
        do_op(2'b00, 1'b0, 64'd5, 64'd0, 2, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(2'b10, 1'b0, 64'd5, 64'd0, 2, 0, 0, 1, 64'd5);
        do_op(2'b11, 1'b1, 64'h1_8000_0000, 64'd0, 3, 0, 0, 1, 64'hFFFF_FFFF_8000_0000);
        // Signed overflow
        do_op(2'b00, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 1, MIN64);
        do_op(2'b10, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 1, 64'd0);
        do_op(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 2, 0, 0, 1, 64'hFFFF_FFFF_8000_0000);
        // General patterns, held results, start+done collision
        do_op(2'b00, 1'b0, 64'd100, -64'sd7, 5, 3, 0, 1, 64'hFFFF_FFFF_FFFF_FFF2);
        do_op(2'b01, 1'b0, 64'hF000_0000_0000_0001, 64'd3, 2, 3, 1, 0, '0);
        do_op(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 1, 1, 0, 1, 64'd5);
        do_op(2'b10, 1'b0, 64'd7, -64'sd3, 2, 0, 0, 1, 64'd1);
        do_op(2'b00, 1'b1, 64'hDEAD_0000_0000_0064, 64'h0000_0000_FFFF_FFF9, 3, 2, 0, 1,
              64'hFFFF_FFFF_FFFF_FFF2);
        do_op(2'b11, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd16, 2, 0, 0, 1, 64'd15);

        // Reset while waiting on the core; the late core_done must be ignored
        start = 1'b1; srcA = 64'd40; srcB = 64'd6; control = 2'b00; isword = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; mdl_busy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mdl_busy = 1'b0; mdl_valid = 1'b0;
        chk("rst_mid_result", result, 64'd0);
        core_done = 1'b1; quotient = 64'd6; remainder = 64'd4;
        @(posedge clk); #1;
        core_done = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("rst_mid_result_after", result, 64'd0);
        $display("op reset-in-wait then stray core_done");

        // Back-to-back op after the reset scenario
        do_op(2'b01, 1'b0, 64'd1000, 64'd7, 2, 0, 0, 1, 64'd142);

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
